gpio_int_ctrl: RTL

Interrupt controller that sits between the GPIO interrupt block's 16-bit `IntStatus` vector and the CPU's single `Irq` line. It masks sources, selects one pending source by fixed or round-robin priority, and presents its index through a claim register. On software completion it issues a one-cycle `IntReset` pulse back to the GPIO block to clear the serviced bit. It shares the GPIO register-bus style: 3-bit `Addr`, 16-bit data, and `En`/`Rd`/`Wr` strobes.

---
 rtl/gpio_int_pkg.sv | 23 ++
 rtl/int_prio_enc.sv | 23 ++
 rtl/gpio_int_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gpio_int_pkg.sv
// Shared types and constants for the GPIO interrupt controller.
package gpio_int_pkg;

    localparam int unsigned NSRC            = 16;
    localparam int unsigned CLAIM_VALID_BIT = 15;

    localparam logic [2:0] ADDR_MASK     = 3'd0;
    localparam logic [2:0] ADDR_PENDING  = 3'd1;
    localparam logic [2:0] ADDR_CLAIM    = 3'd2;
    localparam logic [2:0] ADDR_COMPLETE = 3'd3;
    localparam logic [2:0] ADDR_MODE     = 3'd4;
    localparam logic [2:0] ADDR_RAW      = 3'd5;
    localparam logic [2:0] ADDR_ERR      = 3'd6;
    localparam logic [2:0] ADDR_RSVD     = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StServ,
        StClr
    } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder; the search begins at Start and wraps.
module int_prio_enc
    import gpio_int_pkg::*;
(
    input  logic [NSRC-1:0] Req,
    input  logic [3:0]      Start,
    output logic            Any,
    output logic [3:0]      Idx
);

    // First set request at or after Start, wrapping modulo 16.
    always_comb begin
        Any = 1'b0;
        Idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!Any && Req[Start + 4'(i)]) begin
                Any = 1'b1;
                Idx = Start + 4'(i);
            end
        end
    end

endmodule

// File: rtl/gpio_int_ctrl.sv
// Masks GPIO interrupt sources, arbitrates one, and runs the claim/complete handshake.
module gpio_int_ctrl
    import gpio_int_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic [2:0]      Addr,
    output logic [15:0]     DataRd,
    input  logic [15:0]     DataWr,
    input  logic            En,
    input  logic            Rd,
    input  logic            Wr,
    input  logic [NSRC-1:0] IntStatus,
    output logic [NSRC-1:0] IntReset,
    output logic            Irq
);

    state_t          stateQ, stateD;
    logic [NSRC-1:0] maskQ, maskD;
    logic            modeQ, modeD;
    logic [3:0]      vecQ, vecD;
    logic [3:0]      lastVecQ, lastVecD;
    logic            errQ, errD;
    logic            irqQ, irqD;
    logic [NSRC-1:0] intResetQ, intResetD;

    logic [NSRC-1:0] pending;
    logic [3:0]      arbStart, arbIdx;
    logic            arbAny;
    logic            rdClaim, wrComplete, wrMask, wrMode, wrErr;
    logic            valid;

    // Bus strobe decode and arbitration inputs.
    always_comb begin
        pending    = IntStatus & maskQ;
        rdClaim    = En & Rd & (Addr == ADDR_CLAIM);
        wrComplete = En & Wr & (Addr == ADDR_COMPLETE);
        wrMask     = En & Wr & (Addr == ADDR_MASK);
        wrMode     = En & Wr & (Addr == ADDR_MODE);
        wrErr      = En & Wr & (Addr == ADDR_ERR);
        arbStart   = modeQ ? lastVecQ + 4'd1 : 4'd0;
        valid      = (stateQ == StPend) || (stateQ == StServ);
    end

    int_prio_enc uPrioEnc (
        .Req   (pending),
        .Start (arbStart),
        .Any   (arbAny),
        .Idx   (arbIdx)
    );

    // Configuration register next-state; writes apply in any state.
    always_comb begin
        maskD = wrMask ? DataWr : maskQ;
        modeD = wrMode ? DataWr[0] : modeQ;
    end

    // Claim/complete state machine and registered outputs.
    always_comb begin
        stateD    = stateQ;
        vecD      = vecQ;
        lastVecD  = lastVecQ;
        errD      = errQ;
        intResetD = '0;
        if (wrErr && DataWr[0]) begin
            errD = 1'b0;
        end
        unique case (stateQ)
            StIdle: begin
                if (arbAny) begin
                    vecD   = arbIdx;
                    stateD = StPend;
                end
            end
            StPend: begin
                // A claim in the same cycle as a withdrawal still wins.
                if (rdClaim) begin
                    stateD = StServ;
                end else if (!pending[vecQ]) begin
                    stateD = StIdle;
                end
            end
            StServ: begin
                if (wrComplete) begin
                    if (DataWr[3:0] == vecQ) begin
                        intResetD = {{(NSRC-1){1'b0}}, 1'b1} << vecQ;
                        lastVecD  = vecQ;
                        stateD    = StClr;
                    end else begin
                        errD = 1'b1;
                    end
                end
            end
            StClr: begin
                // One cycle so the GPIO block's cleared status is seen in IDLE.
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
        // Irq only holds while we stay in PEND, so withdrawal or claim drops it next edge.
        irqD = (stateQ == StPend) && (stateD == StPend);
    end

    // State and register update with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            stateQ    <= StIdle;
            maskQ     <= '0;
            modeQ     <= 1'b0;
            vecQ      <= '0;
            lastVecQ  <= 4'd15;
            errQ      <= 1'b0;
            irqQ      <= 1'b0;
            intResetQ <= '0;
        end else begin
            stateQ    <= stateD;
            maskQ     <= maskD;
            modeQ     <= modeD;
            vecQ      <= vecD;
            lastVecQ  <= lastVecD;
            errQ      <= errD;
            irqQ      <= irqD;
            intResetQ <= intResetD;
        end
    end

    assign Irq      = irqQ;
    assign IntReset = intResetQ;

    // Combinational register read mux; zero when deselected or unmapped.
    always_comb begin
        DataRd = '0;
        if (En) begin
            case (Addr)
                ADDR_MASK:    DataRd = maskQ;
                ADDR_PENDING: DataRd = pending;
                ADDR_CLAIM: begin
                    DataRd[CLAIM_VALID_BIT] = valid;
                    DataRd[3:0]             = valid ? vecQ : 4'd0;
                end
                ADDR_MODE:    DataRd[0] = modeQ;
                ADDR_RAW:     DataRd = IntStatus;
                ADDR_ERR:     DataRd[0] = errQ;
                default:      DataRd = '0;
            endcase
        end
    end

endmodule
